// File: rtl/drac_pkg.sv
// Shared types and sizing for the ID->IR instruction queue.
// Holds the stage record carried between decode and rename.
package drac_pkg;

    localparam int INSTRUCTION_QUEUE_NUM_ENTRIES = 8;
    localparam int IQ_NUM_WR = 2;
    localparam int IQ_NUM_RD = 2;

    localparam int IQ_PTR_W = $clog2(INSTRUCTION_QUEUE_NUM_ENTRIES);
    localparam int IQ_CNT_W = $clog2(INSTRUCTION_QUEUE_NUM_ENTRIES + 1);

    typedef logic [IQ_PTR_W-1:0] iq_ptr_t;
    typedef logic [IQ_CNT_W-1:0] iq_cnt_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] bits;
    } instr_entry_t;

    typedef struct packed {
        instr_entry_t instr;
        logic [5:0]   prs1;
        logic [5:0]   prs2;
        logic [5:0]   prd;
    } id_ir_stage_t;

endpackage

// File: rtl/iq_lane_compactor.sv
// Packs sparse valid write lanes into consecutive queue slots, limited by free space.
// Purely combinational: accept mask, per-lane slot offset from tail, and accepted count.
module iq_lane_compactor
    import drac_pkg::*;
#(
    parameter int NUM_WR = IQ_NUM_WR,
    parameter int PTR_W  = IQ_PTR_W,
    parameter int CNT_W  = IQ_CNT_W
) (
    input  logic [NUM_WR-1:0] valid,
    input  logic [CNT_W-1:0]  free,
    output logic [NUM_WR-1:0] accept,
    output logic [PTR_W-1:0]  offset [NUM_WR],
    output logic [CNT_W-1:0]  enq_n
);

    always_comb begin
        logic [CNT_W-1:0] below;
        // NOTE: blocking '=' so 'below' and 'enq_n' accumulate lane by lane within one evaluation.
        below  = '0;
        enq_n  = '0;
        accept = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            // Accepted lanes are always a prefix of the valid lanes, so
            // the valid-lanes-below count doubles as the packed slot offset.
            accept[k] = valid[k] && (below < free);
            offset[k] = below[PTR_W-1:0];
            if (valid[k]) begin
                below = below + CNT_W'(1);
            end
            if (accept[k]) begin
                enq_n = enq_n + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/multi_issue_instruction_queue.sv
// In-order multi-issue FIFO between ID and IR: compacting multi-lane enqueue,
// prefix dequeue of the oldest NUM_RD entries, occupancy reporting and flush.
module multi_issue_instruction_queue
    import drac_pkg::*;
#(
    parameter  int NUM_ENTRIES = INSTRUCTION_QUEUE_NUM_ENTRIES,
    parameter  int NUM_WR      = IQ_NUM_WR,
    parameter  int NUM_RD      = IQ_NUM_RD,
    localparam int PTR_W       = $clog2(NUM_ENTRIES),
    localparam int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  id_ir_stage_t       instr_i [NUM_WR],
    output logic [NUM_WR-1:0]  accept_o,
    output id_ir_stage_t       instr_o [NUM_RD],
    output logic [NUM_RD-1:0]  valid_o,
    input  logic [NUM_RD-1:0]  deq_i,
    output logic [CNT_W-1:0]   count_o,
    output logic [CNT_W-1:0]   free_o,
    output logic               full_o,
    output logic               empty_o
);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    ptr_t         head_q;
    ptr_t         tail_q;
    cnt_t         count_q;
    id_ir_stage_t mem [NUM_ENTRIES];

    logic              hold;
    logic [NUM_WR-1:0] lane_valid;
    logic [NUM_WR-1:0] lane_accept;
    ptr_t              lane_offset [NUM_WR];
    cnt_t              free_cnt;
    cnt_t              enq_n;
    cnt_t              deq_n;
    logic [CNT_W:0]    count_sum;

    // Reset and flush both discard the queue; neither may write or consume.
    assign hold = rst_i | flush_i;

    always_comb begin
        for (int k = 0; k < NUM_WR; k++) begin
            lane_valid[k] = instr_i[k].instr.valid & ~hold;
        end
    end

    // Free space is taken from the registered count, so same-cycle dequeues never free a slot.
    assign free_cnt = cnt_t'(NUM_ENTRIES) - count_q;

    iq_lane_compactor #(
        .NUM_WR (NUM_WR),
        .PTR_W  (PTR_W),
        .CNT_W  (CNT_W)
    ) u_compactor (
        .valid  (lane_valid),
        .free   (free_cnt),
        .accept (lane_accept),
        .offset (lane_offset),
        .enq_n  (enq_n)
    );

    assign accept_o = lane_accept;

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            valid_o[k] = count_q > cnt_t'(k);
            instr_o[k] = valid_o[k] ? mem[head_q + ptr_t'(k)] : '0;
        end
    end

    always_comb begin
        logic run;
        run   = ~hold;
        deq_n = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            run = run & deq_i[k] & valid_o[k];
            if (run) begin
                deq_n = deq_n + cnt_t'(1);
            end
        end
    end

    assign count_sum = {1'b0, count_q} + {1'b0, enq_n} - {1'b0, deq_n};

    // NOTE: non-blocking '<=' for all registered state so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (hold) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + ptr_t'(deq_n);
            tail_q  <= tail_q + ptr_t'(enq_n);
            count_q <= count_sum[CNT_W-1:0];
        end
    end

    // NOTE: payload storage has no reset; valid_o masks stale slots, and resetting it would only cost flops.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_WR; k++) begin
            if (lane_accept[k]) begin
                mem[tail_q + lane_offset[k]] <= instr_i[k];
            end
        end
    end

    assign count_o = count_q;
    assign free_o  = free_cnt;
    assign full_o  = count_q == cnt_t'(NUM_ENTRIES);
    assign empty_o = count_q == '0;

    a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= cnt_t'(NUM_ENTRIES));

    a_ptr_consistent : assert property (@(posedge clk_i) disable iff (rst_i)
        (head_q + ptr_t'(count_q)) == tail_q);

    a_valid_thermo : assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_o & (valid_o + NUM_RD'(1))) == '0);

    a_count_no_wrap : assert property (@(posedge clk_i) disable iff (rst_i)
        count_sum[CNT_W] == 1'b0);

endmodule

// File: tb/tb_multi_issue_instruction_queue.sv
// Scoreboard bench for multi_issue_instruction_queue: directed scenarios then random traffic.
module tb_multi_issue_instruction_queue;
    import drac_pkg::*;

    localparam int N = 8;
    localparam int W = 2;
    localparam int R = 2;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         flush_i = 1'b0;
    id_ir_stage_t instr_i [W];
    logic [W-1:0] accept_o;
    id_ir_stage_t instr_o [R];
    logic [R-1:0] valid_o;
    logic [R-1:0] deq_i = '1;
    logic [3:0]   count_o;
    logic [3:0]   free_o;
    logic         full_o;
    logic         empty_o;

    multi_issue_instruction_queue dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush_i  (flush_i),
        .instr_i  (instr_i),
        .accept_o (accept_o),
        .instr_o  (instr_o),
        .valid_o  (valid_o),
        .deq_i    (deq_i),
        .count_o  (count_o),
        .free_o   (free_o),
        .full_o   (full_o),
        .empty_o  (empty_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    int unsigned seq = 1;
    int unsigned last_seq = 0;

    // Expected queue contents, oldest first; also the scoreboard the monitor pops from.
    id_ir_stage_t sb_q[$];
    id_ir_stage_t pending[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic id_ir_stage_t make(input bit v);
        id_ir_stage_t p;
        p.instr.valid = v;
        p.instr.pc    = v ? seq : $urandom;
        p.instr.bits  = $urandom;
        p.prs1        = 6'($urandom);
        p.prs2        = 6'($urandom);
        p.prd         = 6'($urandom);
        if (v) seq++;
        return p;
    endfunction

    // One clock cycle: drive at posedge+1, check status at posedge+2, apply model after the edge.
    task automatic cycle(input bit rst, input bit fl, input bit [W-1:0] vmask, input bit [R-1:0] deq);
        int           size;
        int           below;
        bit [W-1:0]   exp_acc;
        id_ir_stage_t exp_slot;
        rst_i   = rst;
        flush_i = fl;
        deq_i   = deq;
        for (int k = 0; k < W; k++) instr_i[k] = make(vmask[k]);
        #1;
        size    = sb_q.size();
        below   = 0;
        exp_acc = '0;
        pending.delete();
        for (int k = 0; k < W; k++) begin
            if (vmask[k]) begin
                if (!rst && !fl && below < (N - size)) begin
                    exp_acc[k] = 1'b1;
                    pending.push_back(instr_i[k]);
                end
                below++;
            end
        end
        check("accept_o", 128'(accept_o), 128'(exp_acc));
        check("count_o",  128'(count_o),  128'(size));
        check("free_o",   128'(free_o),   128'(N - size));
        check("full_o",   128'(full_o),   128'(size == N));
        check("empty_o",  128'(empty_o),  128'(size == 0));
        for (int k = 0; k < R; k++) begin
            exp_slot = (k < size) ? sb_q[k] : '0;
            check("valid_o", 128'(valid_o[k]), 128'(k < size));
            check("instr_o", 128'(instr_o[k]), 128'(exp_slot));
        end
        @(posedge clk_i);
        #1;
        if (rst || fl) begin
            sb_q.delete();
        end else begin
            foreach (pending[i]) sb_q.push_back(pending[i]);
        end
    endtask

    // Monitor: on every consumed slot, pop the scoreboard and compare payload and ordering.
    always @(negedge clk_i) begin
        bit           go;
        id_ir_stage_t e;
        if (!rst_i && !flush_i) begin
            go = 1'b1;
            for (int k = 0; k < R; k++) begin
                go = go && deq_i[k] && (sb_q.size() > 0);
                if (go) begin
                    e = sb_q.pop_front();
                    check("deq_payload", 128'(instr_o[k]), 128'(e));
                    check("deq_order", 128'(e.instr.pc > last_seq), 128'(1));
                    last_seq = e.instr.pc;
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < W; k++) instr_i[k] = make(1'b1);
        @(posedge clk_i);
        #1;
        // Second reset edge with traffic present; status must already show reset values.
        cycle(1, 0, 2'b11, 2'b11);

        // Sparse enqueue: A on lane 1 only, then B and C.
        cycle(0, 0, 2'b10, 2'b00);
        cycle(0, 0, 2'b11, 2'b00);
        cycle(0, 0, 2'b00, 2'b11);
        cycle(0, 0, 2'b00, 2'b00);

        // Fill to 7, then partial accept to full, then full with dequeue of one.
        for (int i = 0; i < 3; i++) cycle(0, 0, 2'b11, 2'b00);
        cycle(0, 0, 2'b11, 2'b00);
        cycle(0, 0, 2'b11, 2'b01);

        // Drain to 3, non-prefix dequeue, then over-asked dequeue at count 1.
        cycle(0, 0, 2'b00, 2'b11);
        cycle(0, 0, 2'b00, 2'b11);
        cycle(0, 0, 2'b00, 2'b10);
        cycle(0, 0, 2'b00, 2'b11);
        cycle(0, 0, 2'b00, 2'b11);
        cycle(0, 0, 2'b00, 2'b00);

        // Pointer wrap-around with steady two-in/two-out traffic.
        for (int i = 0; i < 20; i++) cycle(0, 0, 2'b11, 2'b11);
        cycle(0, 0, 2'b00, 2'b11);
        cycle(0, 0, 2'b00, 2'b11);

        // Flush at count 5 with traffic, then flush and reset together.
        cycle(0, 0, 2'b11, 2'b00);
        cycle(0, 0, 2'b11, 2'b00);
        cycle(0, 0, 2'b01, 2'b00);
        cycle(0, 1, 2'b11, 2'b11);
        cycle(0, 0, 2'b00, 2'b00);
        cycle(0, 0, 2'b11, 2'b00);
        cycle(0, 0, 2'b11, 2'b00);
        cycle(1, 1, 2'b11, 2'b11);
        cycle(0, 0, 2'b00, 2'b00);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 29) == 0),
                  2'($urandom), 2'($urandom));
        end
        cycle(0, 0, 2'b00, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
